// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard controller.
package fwd_pkg;

  localparam logic [3:0] OPC_LOAD = 4'd10;

  localparam logic [1:0] SEL_RF   = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_WB   = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  typedef enum logic {IDLE, MEM_WAIT} fsm_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding / hazard controller.
interface fwd_hazard_unit_if #(
  parameter int REG_AW = 3,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
);
  logic                     fwd_en;
  logic                     ex_valid;
  logic [NSRC*REG_AW-1:0]   ex_src;
  logic [NSRC-1:0]          ex_src_used;
  logic                     mem_valid;
  logic                     mem_wb;
  logic                     mem_is_load;
  logic [REG_AW-1:0]        mem_reg;
  logic                     mem_ready;
  logic                     wb_valid;
  logic                     wb_wb;
  logic [REG_AW-1:0]        wb_reg;
  logic                     cnt_clr;
  logic [NSRC*2-1:0]        alu_sel;
  logic                     stall;
  logic                     freeze_mem;
  logic                     bubble;
  logic                     mem_timeout;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output fwd_en, ex_valid, ex_src, ex_src_used, mem_valid, mem_wb, mem_is_load,
           mem_reg, mem_ready, wb_valid, wb_wb, wb_reg, cnt_clr,
    input  alu_sel, stall, freeze_mem, bubble, mem_timeout, stall_cnt
  );

  modport slave (
    input  fwd_en, ex_valid, ex_src, ex_src_used, mem_valid, mem_wb, mem_is_load,
           mem_reg, mem_ready, wb_valid, wb_wb, wb_reg, cnt_clr,
    output alu_sel, stall, freeze_mem, bubble, mem_timeout, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit_src_match.sv
// Priority comparator choosing the operand source for one EX source register.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 3,
  parameter bit HOLD_EN = 1'b1
) (
  input  logic              en,
  input  logic              used,
  input  logic [REG_AW-1:0] src,
  input  logic              mem_fwd,
  input  logic [REG_AW-1:0] mem_reg,
  input  logic              wb_fwd,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic              hold_valid,
  input  logic [REG_AW-1:0] hold_reg,
  output logic [1:0]        sel
);

  // MEM beats WB beats hold tag; r0 is hard-wired and never forwarded
  always_comb begin
    sel = SEL_RF;
    if (en && used && (src != '0)) begin
      if (mem_fwd && (src == mem_reg))
        sel = SEL_MEM;
      else if (wb_fwd && (src == wb_reg))
        sel = SEL_WB;
      else if (HOLD_EN && hold_valid && (src == hold_reg))
        sel = SEL_HOLD;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select, load-use stall and memory-wait sequencing for EX/MEM/WB.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int NSRC        = 2,
  parameter int OPC_W       = 4,
  parameter bit HOLD_EN     = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst_n,
  fwd_hazard_unit_if.slave  bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  if (OPC_W < $bits(OPC_LOAD)) begin : g_opc_chk
    $error("OPC_W too narrow to hold OPC_LOAD");
  end

  fsm_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              hold_valid;
  logic [REG_AW-1:0] hold_reg;
  logic              timeout_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NSRC*2-1:0] sel_w;
  logic              en, any_mem, hazard;
  logic              stall_c, freeze_c, bubble_c, timeout_set;

  // Reset also silences the combinational outputs
  assign en = bus.fwd_en & rst_n;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_match #(.REG_AW(REG_AW), .HOLD_EN(HOLD_EN)) u_match (
      .en         (en),
      .used       (bus.ex_src_used[i]),
      .src        (bus.ex_src[i*REG_AW +: REG_AW]),
      .mem_fwd    (bus.mem_valid & bus.mem_wb),
      .mem_reg    (bus.mem_reg),
      .wb_fwd     (bus.wb_valid & bus.wb_wb),
      .wb_reg     (bus.wb_reg),
      .hold_valid (hold_valid),
      .hold_reg   (hold_reg),
      .sel        (sel_w[i*2 +: 2])
    );
  end

  // Any source currently forwarded from MEM
  always_comb begin
    any_mem = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (sel_w[i*2 +: 2] == SEL_MEM) any_mem = 1'b1;
  end

  assign hazard = en & bus.ex_valid & bus.mem_valid & bus.mem_is_load & bus.mem_wb & any_mem;

  // Next-state and stall/freeze/bubble decode
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    stall_c     = 1'b0;
    freeze_c    = 1'b0;
    bubble_c    = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (en && bus.mem_valid && bus.mem_is_load && !bus.mem_ready) begin
          stall_c   = 1'b1;
          freeze_c  = 1'b1;
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else if (hazard && bus.mem_ready) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!en) begin
          state_nxt = IDLE;
          wait_nxt  = '0;
        end else if (bus.mem_ready) begin
          stall_c   = hazard;
          bubble_c  = hazard;
          state_nxt = IDLE;
          wait_nxt  = '0;
        end else if (wait_cnt < WAIT_MAX) begin
          stall_c  = 1'b1;
          freeze_c = 1'b1;
          wait_nxt = wait_cnt + 1'b1;
        end else begin
          timeout_set = 1'b1;
          state_nxt   = IDLE;
          wait_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        wait_nxt  = '0;
      end
    endcase
  end

  // Control state: FSM, wait counter, sticky timeout, stall counter, hold valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      hold_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (timeout_set) timeout_q <= 1'b1;
      if (bus.cnt_clr)
        cnt_q <= '0;
      else if (stall_c && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
      if (bus.wb_valid && bus.wb_wb && (bus.wb_reg != '0)) hold_valid <= 1'b1;
    end
  end

  // Hold tag register id follows the last real WB write
  always_ff @(posedge clk) begin
    if (bus.wb_valid && bus.wb_wb && (bus.wb_reg != '0)) hold_reg <= bus.wb_reg;
  end

  assign bus.alu_sel     = sel_w;
  assign bus.stall       = stall_c;
  assign bus.freeze_mem  = freeze_c;
  assign bus.bubble      = bubble_c;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit with directed vectors.
module tb_fwd_hazard_unit;

  localparam int CW = 4;

  logic clk;
  logic rst_n;

  fwd_hazard_unit_if #(.REG_AW(3), .NSRC(2), .CNT_W(CW)) bus ();

  fwd_hazard_unit #(
    .REG_AW(3), .NSRC(2), .OPC_W(4), .HOLD_EN(1'b1), .MEM_TIMEOUT(4), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic       st;
    logic       fr;
    logic       bu;
    logic       to;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, req);
    end
  endtask

  // Monitor: compare the oldest expectation mid-cycle
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        cmp(n, "alu_sel",     bus.alu_sel,            e.sel);
        cmp(n, "stall",       {3'b0, bus.stall},       {3'b0, e.st});
        cmp(n, "freeze_mem",  {3'b0, bus.freeze_mem},  {3'b0, e.fr});
        cmp(n, "bubble",      {3'b0, bus.bubble},      {3'b0, e.bu});
        cmp(n, "mem_timeout", {3'b0, bus.mem_timeout}, {3'b0, e.to});
        cmp(n, "stall_cnt",   bus.stall_cnt,          e.cnt);
      end
    end
  end

  task automatic expect_cyc(input string nm, input logic [3:0] sel, input logic st, input logic fr,
                            input logic bu, input logic to, input logic [3:0] cnt);
    exp_t e;
    e = '{sel: sel, st: st, fr: fr, bu: bu, to: to, cnt: cnt};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.fwd_en = 1'b1; bus.ex_valid = 1'b1; bus.ex_src = '0; bus.ex_src_used = '0;
    bus.mem_valid = 1'b0; bus.mem_wb = 1'b0; bus.mem_is_load = 1'b0; bus.mem_reg = '0;
    bus.mem_ready = 1'b1; bus.wb_valid = 1'b0; bus.wb_wb = 1'b0; bus.wb_reg = '0;
    bus.cnt_clr = 1'b0;
  endtask

  task automatic set_mem(input logic v, input logic wb, input logic ld, input logic [2:0] r, input logic rdy);
    bus.mem_valid = v; bus.mem_wb = wb; bus.mem_is_load = ld; bus.mem_reg = r; bus.mem_ready = rdy;
  endtask

  task automatic set_wb(input logic v, input logic wb, input logic [2:0] r);
    bus.wb_valid = v; bus.wb_wb = wb; bus.wb_reg = r;
  endtask

  task automatic set_src(input logic [2:0] s1, input logic [2:0] s0, input logic [1:0] used);
    bus.ex_src = {s1, s0}; bus.ex_src_used = used;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    // reset: a MEM match is present but outputs must stay 0
    set_src(3'd0, 3'd3, 2'b01); set_mem(1, 1, 0, 3'd3, 1); set_wb(1, 1, 3'd3);
    expect_cyc("reset", 4'b0000, 0, 0, 0, 0, 4'd0);
    rst_n = 1'b1;

    // MEM beats WB, then WB alone
    expect_cyc("mem_prio", 4'b0001, 0, 0, 0, 0, 4'd0);
    bus.mem_wb = 1'b0;
    expect_cyc("wb_sel", 4'b0010, 0, 0, 0, 0, 4'd0);

    // r0 never forwards; fwd_en=0 silences everything
    set_src(3'd0, 3'd0, 2'b01); set_mem(1, 1, 0, 3'd0, 1); set_wb(0, 0, 3'd0);
    expect_cyc("r0", 4'b0000, 0, 0, 0, 0, 4'd0);
    bus.fwd_en = 1'b0; set_src(3'd0, 3'd3, 2'b01); set_mem(1, 1, 1, 3'd3, 0);
    expect_cyc("fwd_off", 4'b0000, 0, 0, 0, 0, 4'd0);

    // load-use with data ready: one stall+bubble, then WB forward
    bus.fwd_en = 1'b1; set_src(3'd5, 3'd0, 2'b10); set_mem(1, 1, 1, 3'd5, 1);
    expect_cyc("ld_use", 4'b0100, 1, 0, 1, 0, 4'd0);
    set_mem(0, 0, 0, 3'd0, 1); set_wb(1, 1, 3'd5); bus.cnt_clr = 1'b1;
    expect_cyc("ld_wb", 4'b1000, 0, 0, 0, 0, 4'd1);

    // memory wait of 3 cycles without dependency
    bus.cnt_clr = 1'b0; set_src(3'd0, 3'd0, 2'b00); set_wb(0, 0, 3'd0); set_mem(1, 1, 1, 3'd6, 0);
    expect_cyc("wait0", 4'b0000, 1, 1, 0, 0, 4'd0);
    expect_cyc("wait1", 4'b0000, 1, 1, 0, 0, 4'd1);
    expect_cyc("wait2", 4'b0000, 1, 1, 0, 0, 4'd2);
    bus.mem_ready = 1'b1;
    expect_cyc("wait_done", 4'b0000, 0, 0, 0, 0, 4'd3);

    // timeout after MEM_TIMEOUT stalled cycles
    bus.mem_ready = 1'b0;
    expect_cyc("tmo0", 4'b0000, 1, 1, 0, 0, 4'd3);
    expect_cyc("tmo1", 4'b0000, 1, 1, 0, 0, 4'd4);
    expect_cyc("tmo2", 4'b0000, 1, 1, 0, 0, 4'd5);
    expect_cyc("tmo3", 4'b0000, 1, 1, 0, 0, 4'd6);
    expect_cyc("tmo_hit", 4'b0000, 0, 0, 0, 0, 4'd7);
    set_mem(0, 0, 0, 3'd0, 1);
    expect_cyc("tmo_sticky", 4'b0000, 0, 0, 0, 1, 4'd7);

    // hold tag one cycle after WB write of r2
    set_wb(1, 1, 3'd2); set_src(3'd0, 3'd2, 2'b01);
    expect_cyc("wb_r2", 4'b0010, 0, 0, 0, 1, 4'd7);
    set_wb(0, 0, 3'd0);
    expect_cyc("hold", 4'b0011, 0, 0, 0, 1, 4'd7);

    // stall counter saturation, then clear wins over increment
    set_src(3'd5, 3'd0, 2'b10); set_mem(1, 1, 1, 3'd5, 1);
    for (int k = 0; k < 10; k++)
      expect_cyc("sat", 4'b0100, 1, 0, 1, 1, (7 + k > 15) ? 4'd15 : 4'(7 + k));
    bus.cnt_clr = 1'b1;
    expect_cyc("clr_stall", 4'b0100, 1, 0, 1, 1, 4'd15);
    bus.cnt_clr = 1'b0; set_mem(0, 0, 0, 3'd0, 1); set_src(3'd0, 3'd0, 2'b00);
    expect_cyc("cleared", 4'b0000, 0, 0, 0, 1, 4'd0);

    // async reset in the middle of MEM_WAIT
    set_src(3'd0, 3'd2, 2'b01); set_mem(1, 1, 1, 3'd2, 0);
    expect_cyc("rw0", 4'b0001, 1, 1, 0, 1, 4'd0);
    expect_cyc("rw1", 4'b0001, 1, 1, 0, 1, 4'd1);
    rst_n = 1'b0;
    expect_cyc("rst_mid", 4'b0000, 0, 0, 0, 0, 4'd0);
    rst_n = 1'b1; set_mem(0, 0, 0, 3'd0, 1);
    expect_cyc("hold_clr", 4'b0000, 0, 0, 0, 0, 4'd0);

    // fwd_en dropping during MEM_WAIT
    set_src(3'd0, 3'd0, 2'b00); set_mem(1, 1, 1, 3'd6, 0);
    expect_cyc("fd0", 4'b0000, 1, 1, 0, 0, 4'd0);
    bus.cnt_clr = 1'b1;
    expect_cyc("fd1", 4'b0000, 1, 1, 0, 0, 4'd1);
    bus.cnt_clr = 1'b0; bus.fwd_en = 1'b0;
    expect_cyc("fd_off", 4'b0000, 0, 0, 0, 0, 4'd0);
    bus.fwd_en = 1'b1; set_mem(0, 0, 0, 3'd0, 1);
    expect_cyc("fd_idle", 4'b0000, 0, 0, 0, 0, 4'd0);

    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
